brentkung_mp_seq: RTL and testbench



---
 rtl/brentkung_mp_seq.sv | 171 +++++++++++++++++
 tb/tb_brentkung_mp_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/brentkung_mp_seq.sv
// Multi-precision adder sequencer built around one N-bit Brent-Kung prefix adder.
// A WORDS*N-bit addition is performed one N-bit slice per cycle, least
// significant slice first, with the slice carry held in a register.

// Combinational N-bit Brent-Kung parallel-prefix adder with carry in/out.
module BrentKung_par #(
  parameter int N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  localparam int LOGN = $clog2(N);
  localparam int TOPD = (1 << LOGN) / 2;

  logic [N-1:0] prop;
  logic [N-1:0] grpG;
  logic [N-1:0] grpP;
  logic [N:0]   carry;

  // Up-sweep builds power-of-two group terms, down-sweep fills the gaps,
  // then each bit's carry is the group generate/propagate from bit 0 applied to cin.
  always_comb begin
    prop  = a_i ^ b_i;
    grpG  = a_i & b_i;
    grpP  = prop;
    carry = '0;
    for (int d = 1; d < N; d = d * 2) begin
      for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
        grpG[i] = grpG[i] | (grpP[i] & grpG[i-d]);
        grpP[i] = grpP[i] & grpP[i-d];
      end
    end
    for (int d = TOPD; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
        grpG[i] = grpG[i] | (grpP[i] & grpG[i-d]);
        grpP[i] = grpP[i] & grpP[i-d];
      end
    end
    carry[0] = cin_i;
    for (int i = 0; i < N; i++) begin
      carry[i+1] = grpG[i] | (grpP[i] & cin_i);
    end
    sum_o  = prop ^ carry[N-1:0];
    cout_o = carry[N];
  end

endmodule

// Sequencer: IDLE waits for start, RUN walks the slices, DONE presents the result.
module brentkung_mp_seq #(
  parameter int N     = 16,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N*WORDS-1:0] a_in,
  input  logic [N*WORDS-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [N*WORDS-1:0] sum_out,
  output logic             cout
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW = (WORDS - 1) * N;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [N*WORDS-1:0] a_q, a_d;
  logic [N*WORDS-1:0] b_q, b_d;
  logic [PW-1:0]      part_q, part_d;
  logic               carry_q, carry_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [N*WORDS-1:0] sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [N-1:0] sliceA;
  logic [N-1:0] sliceB;
  logic [N-1:0] addSum;
  logic         addCout;

  assign sliceA = a_q[idx_q*N +: N];
  assign sliceB = b_q[idx_q*N +: N];

  BrentKung_par #(.N(N)) u_adder (
    .a_i    (sliceA),
    .b_i    (sliceB),
    .cin_i  (carry_q),
    .sum_o  (addSum),
    .cout_o (addCout)
  );

  // Next-state and datapath update; the top slice's sum goes straight into the
  // result register so the partial register only holds the lower slices.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d = addCout;
        if (idx_q == LAST_IDX) begin
          sum_d   = {addSum, part_q};
          cout_d  = addCout;
          state_d = DONE;
        end else begin
          part_d[idx_q*N +: N] = addSum;
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset that discards any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign sum_out = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_brentkung_mp_seq.sv
// Scoreboard bench for brentkung_mp_seq with N=16, WORDS=4.
module tb_brentkung_mp_seq;

  localparam int N     = 16;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t expQ[$];
  exp_t expItem;
  int   passCount = 0;
  int   checkCount = 0;
  int   doneCount = 0;

  brentkung_mp_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W:0] act, input logic [W:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every done cycle pops one expected result; a done with nothing queued is an error.
  always @(negedge clk) begin
    if (done) begin
      doneCount++;
      if (expQ.size() == 0) begin
        checkOutput("spurious_done", {{W{1'b0}}, done}, '0);
      end else begin
        expItem = expQ.pop_front();
        checkOutput("sum_out", {1'b0, sum_out}, {1'b0, expItem.sum});
        checkOutput("cout", {{W{1'b0}}, cout}, {{W{1'b0}}, expItem.cout});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                               input bit push, input logic [W-1:0] expSum, input logic expCout);
    exp_t item;
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    if (push) begin
      item.sum  = expSum;
      item.cout = expCout;
      expQ.push_back(item);
    end
  endtask

  // Ticks until done is seen (bounded); counts edges and busy cycles along the way.
  task automatic waitDone(input bit holdStart, output int lat, output int busyCycles);
    lat = 0;
    busyCycles = 0;
    do begin
      tick();
      lat++;
      if (lat == 1 && !holdStart) start = 1'b0;
      if (busy) busyCycles++;
    end while (!done && lat < 30);
    if (!done) checkOutput("done_timeout", '0, {{W{1'b0}}, 1'b1});
  endtask

  // Stimulus sequence.
  initial begin
    int lat;
    int bc;
    int doneBefore;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;

    repeat (2) tick();
    checkOutput("reset_busy", {{W{1'b0}}, busy}, '0);
    checkOutput("reset_done", {{W{1'b0}}, done}, '0);
    checkOutput("reset_sum", {1'b0, sum_out}, '0);
    checkOutput("reset_cout", {{W{1'b0}}, cout}, '0);
    rst = 1'b0;
    repeat (5) tick();
    checkOutput("idle_busy", {{W{1'b0}}, busy}, '0);
    checkOutput("idle_done", {{W{1'b0}}, done}, '0);
    checkOutput("idle_sum", {1'b0, sum_out}, '0);
    checkOutput("idle_cout", {{W{1'b0}}, cout}, '0);

    applyStimulus(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1, 64'h0000_0000_0001_0000, 1'b0);
    waitDone(0, lat, bc);
    checkOutput("op1_latency", W'(lat), W'(5));
    checkOutput("op1_busy_cycles", W'(bc), W'(4));
    tick();
    checkOutput("op1_done_pulse", {{W{1'b0}}, done}, '0);
    checkOutput("op1_held", {1'b0, sum_out}, {1'b0, 64'h0000_0000_0001_0000});

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    waitDone(0, lat, bc);
    checkOutput("op2_latency", W'(lat), W'(5));
    tick();

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1, 64'h0, 1'b1);
    waitDone(0, lat, bc);
    checkOutput("op3_latency", W'(lat), W'(5));
    tick();

    doneBefore = doneCount;
    applyStimulus(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1,
                  64'h1234_5678_9ABC_DF00, 1'b0);
    tick();
    start = 1'b0;
    tick();
    a_in  = 64'hDEAD_BEEF_0000_1234;
    b_in  = 64'h7777_0000_AAAA_5555;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone(0, lat, bc);
    tick();
    checkOutput("op4_done_count", W'(doneCount - doneBefore), W'(1));
    checkOutput("op4_idle_busy", {{W{1'b0}}, busy}, '0);

    applyStimulus(64'h1, 64'h2, 1'b0, 1, 64'h3, 1'b0);
    waitDone(1, lat, bc);
    checkOutput("b2b_first_latency", W'(lat), W'(5));
    applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1, 64'h1, 1'b1);
    tick();
    start = 1'b0;
    checkOutput("b2b_restart_busy", {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
    checkOutput("b2b_held_sum", {1'b0, sum_out}, {1'b0, 64'h3});
    waitDone(0, lat, bc);
    checkOutput("b2b_spacing", W'(lat + 1), W'(5));
    tick();
    checkOutput("b2b_held_second", {cout, sum_out}, {1'b1, 64'h1});

    applyStimulus(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 0, '0, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrun_rst_busy", {{W{1'b0}}, busy}, '0);
    checkOutput("midrun_rst_done", {{W{1'b0}}, done}, '0);
    checkOutput("midrun_rst_sum", {1'b0, sum_out}, '0);
    checkOutput("midrun_rst_cout", {{W{1'b0}}, cout}, '0);
    repeat (8) tick();

    applyStimulus(64'h5, 64'h3, 1'b1, 1, 64'h9, 1'b0);
    waitDone(0, lat, bc);
    checkOutput("op6_latency", W'(lat), W'(5));
    tick();
    checkOutput("queue_empty", W'(expQ.size()), '0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
